// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared constants and types for the PS/2 keyboard controller.
//               Register select values, STATUS/CTRL bit positions, receiver
//               state enum and a 3-input majority helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    // Register select, taken from adr[2]
    localparam logic REG_DATA   = 1'b0;
    localparam logic REG_STATUS = 1'b1;

    // STATUS bit positions (CTRL writes reuse OVF/PERR/IE positions)
    localparam int ST_EMPTY_BIT   = 0;
    localparam int ST_FULL_BIT    = 1;
    localparam int ST_OVF_BIT     = 2;
    localparam int ST_PERR_BIT    = 3;
    localparam int ST_IE_BIT      = 4;
    localparam int CTRL_FLUSH_BIT = 5;
    localparam int ST_CNT_LSB     = 8;
    localparam int ST_CNT_MSB     = 13;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_e;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_rx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_rx
// Description : PS/2 frame receiver. Synchronizes and glitch-filters the raw
//               PS/2 clock and data, strobes on filtered clock falling edges,
//               and deframes start/8 data/odd parity/stop. Partial frames are
//               dropped after 100 us without a strobe.
// Ports       : clk_i, rst_ni      - system clock, async active-low reset
//               ps2_clk_i/ps2_dat_i - raw connector lines (asynchronous)
//               byte_o              - last received byte (valid with valid_o)
//               valid_o             - one-cycle pulse, good frame
//               err_o               - one-cycle pulse, parity or stop error
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx #(
    parameter int CLKFREQ = 10000000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic [7:0] byte_o,
    output logic       valid_o,
    output logic       err_o
);
    import ps2_pkg::*;

    localparam int TIMEOUT = CLKFREQ / 10000;
    localparam int TW      = $clog2(TIMEOUT + 1);
    // Two sync flops plus three history flops must hold real samples
    // before the filtered clock level can be trusted.
    localparam logic [2:0] WARM_DONE = 3'd5;

    logic [1:0] clk_sync_q, dat_sync_q;
    logic [2:0] clk_hist_q, dat_hist_q;
    logic       clk_f_q, dat_f_q, clk_fd_q;
    logic [2:0] warm_q;
    logic       armed_q;
    logic       strobe;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_hist_q <= 3'b111;
            dat_hist_q <= 3'b111;
            clk_f_q    <= 1'b1;
            dat_f_q    <= 1'b1;
            clk_fd_q   <= 1'b1;
            warm_q     <= 3'd0;
            armed_q    <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
            clk_hist_q <= {clk_hist_q[1:0], clk_sync_q[1]};
            dat_hist_q <= {dat_hist_q[1:0], dat_sync_q[1]};
            clk_f_q    <= maj3(clk_hist_q);
            dat_f_q    <= maj3(dat_hist_q);
            clk_fd_q   <= clk_f_q;
            if (warm_q != WARM_DONE) begin
                warm_q <= warm_q + 3'd1;
            end
            // Arm only on a genuinely observed high level, not the reset value
            if (warm_q == WARM_DONE && maj3(clk_hist_q)) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign strobe = armed_q & clk_fd_q & ~clk_f_q;

    rx_state_e   state_q, state_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        tmo_d    = tmo_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        if (state_q == RX_IDLE) begin
            tmo_d = '0;
            if (strobe && !dat_f_q) begin
                state_d  = RX_DATA;
                bitcnt_d = 3'd0;
            end
        end else if (strobe) begin
            tmo_d = '0;
            case (state_q)
                RX_DATA: begin
                    shift_d  = {dat_f_q, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = RX_PARITY;
                    end
                end
                RX_PARITY: begin
                    par_d   = dat_f_q;
                    state_d = RX_STOP;
                end
                default: begin
                    state_d = RX_IDLE;
                    if (dat_f_q && (^{shift_q, par_q})) begin
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            endcase
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            state_d = RX_IDLE;
            tmo_d   = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= RX_IDLE;
            bitcnt_q <= 3'd0;
            shift_q  <= 8'd0;
            par_q    <= 1'b0;
            tmo_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            tmo_q    <= tmo_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    // shift_q is stable in IDLE until the next frame's first data strobe
    assign byte_o  = shift_q;
    assign valid_o = valid_q;
    assign err_o   = err_q;

endmodule
`default_nettype wire

// File: rtl/ps2_kbd.sv
`default_nettype none
// ============================================================================
// Module      : ps2_kbd
// Description : PS/2 keyboard controller with scan-code FIFO and Wishbone
//               slave register interface (DATA at adr[2]=0, STATUS/CTRL at
//               adr[2]=1) and a level interrupt.
// Ports       : clk_i, rst_ni          - system clock, async active-low reset
//               wb_*                   - 32-bit Wishbone slave
//               ps2_clk_i, ps2_dat_i   - raw PS/2 connector lines
//               interrupt_o            - FIFO not empty and IE set
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_kbd #(
    parameter int CLKFREQ = 10000000,
    parameter int DEPTH   = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    input  logic        ps2_clk_i,
    input  logic        ps2_dat_i,
    output logic        interrupt_o
);
    import ps2_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0] rx_byte;
    logic       rx_valid, rx_err;

    ps2_rx #(.CLKFREQ(CLKFREQ)) u_rx (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .ps2_clk_i (ps2_clk_i),
        .ps2_dat_i (ps2_dat_i),
        .byte_o    (rx_byte),
        .valid_o   (rx_valid),
        .err_o     (rx_err)
    );

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic          ovf_q, perr_q, ie_q;
    logic          seen_q, ack_q;
    logic [31:0]   dat_q, dat_d;

    logic empty, full, req, first, sel_stat;
    logic rd_data, pop, wr_ctrl, flush, push_ok, ovf_set;
    logic [5:0]  cnt6;
    logic [31:0] status;
    logic        w_unused;

    assign req      = wb_cyc_i & wb_stb_i;
    // Act once per strobe: a held strobe is not seen as a new access
    assign first    = req & ~seen_q;
    assign sel_stat = wb_adr_i[2];
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign rd_data  = first & ~wb_we_i & (sel_stat == REG_DATA);
    assign pop      = rd_data & ~empty;
    assign wr_ctrl  = first & wb_we_i & (sel_stat == REG_STATUS) & wb_sel_i[0];
    assign flush    = wr_ctrl & wb_dat_i[CTRL_FLUSH_BIT];
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign push_ok  = rx_valid & (~full | pop);
    assign ovf_set  = rx_valid & full & ~pop;
    assign cnt6     = 6'(count_q);

    assign w_unused = &{1'b0, wb_adr_i[31:3], wb_adr_i[1:0],
                        wb_dat_i[31:6], wb_dat_i[1:0], wb_sel_i[3:1]};

    always_comb begin
        status = '0;
        status[ST_EMPTY_BIT]           = empty;
        status[ST_FULL_BIT]            = full;
        status[ST_OVF_BIT]             = ovf_q;
        status[ST_PERR_BIT]            = perr_q;
        status[ST_IE_BIT]              = ie_q;
        status[ST_CNT_MSB:ST_CNT_LSB]  = cnt6;
    end

    always_comb begin
        dat_d = '0;
        if (first && !wb_we_i) begin
            if (sel_stat == REG_STATUS) begin
                dat_d = status;
            end else if (!empty) begin
                dat_d = {23'd0, 1'b1, mem[rptr_q]};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wptr_q] <= rx_byte;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            perr_q  <= 1'b0;
            ie_q    <= 1'b0;
            seen_q  <= 1'b0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            seen_q <= req;
            ack_q  <= first;
            dat_q  <= dat_d;

            if (flush) begin
                wptr_q  <= '0;
                rptr_q  <= '0;
                count_q <= '0;
            end else begin
                if (push_ok) begin
                    wptr_q <= wptr_q + 1'b1;
                end
                if (pop) begin
                    rptr_q <= rptr_q + 1'b1;
                end
                if (push_ok && !pop) begin
                    count_q <= count_q + 1'b1;
                end else if (!push_ok && pop) begin
                    count_q <= count_q - 1'b1;
                end
            end

            // Setting events win over a simultaneous software clear
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (wr_ctrl && wb_dat_i[ST_OVF_BIT]) begin
                ovf_q <= 1'b0;
            end
            if (rx_err) begin
                perr_q <= 1'b1;
            end else if (wr_ctrl && wb_dat_i[ST_PERR_BIT]) begin
                perr_q <= 1'b0;
            end
            if (wr_ctrl) begin
                ie_q <= wb_dat_i[ST_IE_BIT];
            end
        end
    end

    assign wb_ack_o    = ack_q;
    assign wb_dat_o    = dat_q;
    assign interrupt_o = ie_q & ~empty;

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ps2_kbd
// Description : Self-checking bench for ps2_kbd. 1 MHz system clock with
//               CLKFREQ=1000000 keeps the 100 us timeout and 12.5 kHz PS/2
//               timing in real time while keeping the cycle count small.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_kbd;

    localparam int CLKFREQ  = 1000000;
    localparam int DEPTH    = 8;
    localparam int PS2_HALF = 40000;   // 12.5 kHz PS/2 clock

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] wb_adr = '0;
    logic [31:0] wb_dat_w = '0;
    logic [31:0] wb_dat_r;
    logic        wb_we = 1'b0;
    logic [3:0]  wb_sel = 4'h0;
    logic        wb_cyc = 1'b0;
    logic        wb_stb = 1'b0;
    logic        wb_ack;
    logic        ps2_clk = 1'b1;
    logic        ps2_dat = 1'b1;
    logic        irq;

    ps2_kbd #(.CLKFREQ(CLKFREQ), .DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .wb_adr_i    (wb_adr),
        .wb_dat_i    (wb_dat_w),
        .wb_dat_o    (wb_dat_r),
        .wb_we_i     (wb_we),
        .wb_sel_i    (wb_sel),
        .wb_cyc_i    (wb_cyc),
        .wb_stb_i    (wb_stb),
        .wb_ack_o    (wb_ack),
        .ps2_clk_i   (ps2_clk),
        .ps2_dat_i   (ps2_dat),
        .interrupt_o (irq)
    );

    always #500 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] A_DATA = 32'h0;
    localparam logic [31:0] A_STAT = 32'h4;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] d);
        int waited;
        @(negedge clk);
        wb_adr = adr; wb_we = 1'b0; wb_sel = 4'hF; wb_cyc = 1'b1; wb_stb = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!wb_ack && waited < 8);
        check("ack_latency_rd", waited, 1);
        d = wb_dat_r;
        wb_cyc = 1'b0; wb_stb = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] d, input logic [3:0] sel);
        int waited;
        @(negedge clk);
        wb_adr = adr; wb_we = 1'b1; wb_sel = sel; wb_dat_w = d; wb_cyc = 1'b1; wb_stb = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!wb_ack && waited < 8);
        check("ack_latency_wr", waited, 1);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        ps2_dat = b;
        #(PS2_HALF) ps2_clk = 1'b0;
        #(PS2_HALF) ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit((~^d) ^ bad_par);
        send_bit(~bad_stop);
        ps2_dat = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       bad_par;
        logic       bad_stop;
        logic [5:0] exp_count;
        logic       exp_perr;
    } vec_t;

    vec_t vecs[6];
    logic [31:0] rd;
    logic [31:0] held_d;
    int          acks;

    initial begin
        vecs[0] = '{8'h1C, 1'b0, 1'b0, 6'd1, 1'b0};
        vecs[1] = '{8'h1C, 1'b1, 1'b0, 6'd1, 1'b1};
        vecs[2] = '{8'hFF, 1'b0, 1'b0, 6'd2, 1'b0};
        vecs[3] = '{8'h00, 1'b0, 1'b0, 6'd3, 1'b0};
        vecs[4] = '{8'hA5, 1'b0, 1'b1, 6'd3, 1'b1};
        vecs[5] = '{8'h80, 1'b0, 1'b0, 6'd4, 1'b0};

        // ---------------- reset state ----------------
        repeat (4) @(negedge clk);
        check("rst_ack", {31'd0, wb_ack}, 32'd0);
        check("rst_dat_o", wb_dat_r, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        wb_read(A_STAT, rd);
        check("rst_status", rd, 32'h0000_0001);
        wb_read(A_DATA, rd);
        check("empty_data_read", rd, 32'd0);
        wb_read(A_STAT, rd);
        check("empty_read_no_pop", rd, 32'h0000_0001);

        // ---------------- table-driven frames ----------------
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop);
            wb_read(A_STAT, rd);
            check($sformatf("vec%0d_count", i), {26'd0, rd[13:8]}, {26'd0, vecs[i].exp_count});
            check($sformatf("vec%0d_perr", i), {31'd0, rd[3]}, {31'd0, vecs[i].exp_perr});
            check($sformatf("vec%0d_empty", i), {31'd0, rd[0]}, 32'd0);
            if (vecs[i].exp_perr) begin
                wb_write(A_STAT, 32'h08, 4'h1);
                wb_read(A_STAT, rd);
                check($sformatf("vec%0d_perr_clr", i), {31'd0, rd[3]}, 32'd0);
            end
        end
        wb_write(A_DATA, 32'hFF, 4'hF);
        wb_read(A_STAT, rd);
        check("data_write_ignored", rd, 32'h0000_0400);
        wb_read(A_DATA, rd); check("fifo_rd0", rd, 32'h11C);
        wb_read(A_DATA, rd); check("fifo_rd1", rd, 32'h1FF);
        wb_read(A_DATA, rd); check("fifo_rd2", rd, 32'h100);
        wb_read(A_DATA, rd); check("fifo_rd3", rd, 32'h180);
        wb_read(A_STAT, rd); check("fifo_drained", rd, 32'h0000_0001);

        // ---------------- interrupt ----------------
        send_frame(8'h1C, 1'b0, 1'b0);
        check("irq_ie0", {31'd0, irq}, 32'd0);
        wb_write(A_STAT, 32'h10, 4'h1);
        @(negedge clk);
        check("irq_ie1", {31'd0, irq}, 32'd1);
        wb_write(A_STAT, 32'h00, 4'h2);
        check("sel0_masked", {31'd0, irq}, 32'd1);
        wb_read(A_DATA, rd);
        check("irq_rd_data", rd, 32'h11C);
        check("irq_dropped", {31'd0, irq}, 32'd0);
        wb_read(32'h0000_0F0C, rd);
        check("alias_status", rd, 32'h0000_0011);
        wb_read(32'h0000_0F08, rd);
        check("alias_data_empty", rd, 32'd0);

        // ---------------- overflow, held strobe ----------------
        wb_write(A_STAT, 32'h20, 4'h1);
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0);
        wb_read(A_STAT, rd);
        check("ovf_status", rd, 32'h0000_0806);
        @(negedge clk);
        wb_adr = A_DATA; wb_we = 1'b0; wb_sel = 4'hF; wb_cyc = 1'b1; wb_stb = 1'b1;
        acks = 0; held_d = '0;
        repeat (5) begin
            @(negedge clk);
            if (wb_ack) begin
                acks++;
                held_d = wb_dat_r;
            end
        end
        wb_cyc = 1'b0; wb_stb = 1'b0;
        check("held_ack_count", acks, 1);
        check("held_rd_data", held_d, 32'h101);
        wb_read(A_STAT, rd);
        check("held_single_pop", rd, 32'h0000_0704);
        for (int i = 2; i <= 8; i++) begin
            wb_read(A_DATA, rd);
            check($sformatf("ovf_rd%0d", i), rd, 32'h100 | 32'(i));
        end
        wb_read(A_STAT, rd);
        check("ovf_sticky", rd, 32'h0000_0005);
        wb_write(A_STAT, 32'h04, 4'h1);
        wb_read(A_STAT, rd);
        check("ovf_clr", rd, 32'h0000_0001);

        // ---------------- timeout ----------------
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        ps2_dat = 1'b1;
        #150000;
        send_frame(8'h5A, 1'b0, 1'b0);
        wb_read(A_STAT, rd);
        check("tmo_status", rd, 32'h0000_0100);
        wb_read(A_DATA, rd);
        check("tmo_data", rd, 32'h15A);

        // ---------------- reset mid-frame ----------------
        send_frame(8'h33, 1'b0, 1'b0);
        wb_write(A_STAT, 32'h10, 4'h1);
        @(negedge clk);
        check("pre_rst_irq", {31'd0, irq}, 32'd1);
        send_bit(1'b0); send_bit(1'b1);
        ps2_dat = 1'b0;
        #(PS2_HALF/2) ps2_clk = 1'b0;
        #7300 rst_n = 1'b0;
        #200;
        check("midrst_irq", {31'd0, irq}, 32'd0);
        check("midrst_ack", {31'd0, wb_ack}, 32'd0);
        check("midrst_dat_o", wb_dat_r, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        // line still low after release: must not look like a start bit
        repeat (20) @(negedge clk);
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (20) @(negedge clk);
        wb_read(A_STAT, rd);
        check("post_rst_status", rd, 32'h0000_0001);
        send_frame(8'hE7, 1'b0, 1'b0);
        wb_read(A_DATA, rd);
        check("post_rst_frame", rd, 32'h1E7);
        wb_read(A_STAT, rd);
        check("post_rst_empty", rd, 32'h0000_0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
